// File: rtl/add_datapath.sv
// Datapath responder for the ADD-class control FSM: PC, IR, register file,
// ALU operand latches and result register, plus the boot/run/halt sequencer.
module add_datapath #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          go,
   output logic [AW-1:0] instr_addr,
   input  logic [15:0]   instr_data,
   output logic [3:0]    opCode,
   output logic [5:0]    para1,
   output logic [5:0]    para2,
   output logic          start,
   input  logic [5:0]    paraOut,
   input  logic          aluIn1,
   input  logic          aluIn2,
   input  logic [3:0]    control,
   input  logic          aluOutRegIn,
   input  logic          aluOutRegOut,
   input  logic [5:0]    regIn,
   input  logic          incr,
   input  logic          fetch,
   input  logic          dbg_we,
   input  logic [5:0]    dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic [DW-1:0] result,
   output logic          carry,
   output logic          halted
);

   localparam logic [1:0] S_BOOT = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;

   logic [1:0]    state;
   logic [AW-1:0] pc;
   logic [15:0]   ir;
   logic [DW-1:0] a, b, r;
   logic          cy;
   logic          strt;
   logic [DW-1:0] rf [64];

   logic          run;
   logic          active;
   logic [DW-1:0] rd;
   logic [DW:0]   sum, dif;
   logic [DW-1:0] alu_y;
   logic          alu_c;

   assign run    = (state == S_RUN);
   assign active = (state != S_HALT);
   assign rd     = rf[paraOut];

   assign instr_addr = pc;
   assign opCode     = ir[15:12];
   assign para1      = ir[11:6];
   assign para2      = ir[5:0];
   assign start      = strt;
   assign result     = r;
   assign carry      = cy;
   assign halted     = (state == S_HALT);

   // Carry of a subtract is the borrow, i.e. bit DW of the widened difference.
   always_comb begin
      sum   = {1'b0, a} + {1'b0, b};
      dif   = {1'b0, a} - {1'b0, b};
      alu_y = sum[DW-1:0];
      alu_c = sum[DW];
      case (control)
         4'd0: begin alu_y = sum[DW-1:0]; alu_c = sum[DW]; end
         4'd1: begin alu_y = dif[DW-1:0]; alu_c = dif[DW]; end
         4'd2: begin alu_y = a & b;       alu_c = 1'b0;    end
         4'd3: begin alu_y = a | b;       alu_c = 1'b0;    end
         4'd4: begin alu_y = a ^ b;       alu_c = 1'b0;    end
         4'd5: begin alu_y = ~a;          alu_c = 1'b0;    end
         4'd6: begin alu_y = a;           alu_c = 1'b0;    end
         4'd7: begin alu_y = b;           alu_c = 1'b0;    end
         default: begin
            alu_y = sum[DW-1:0];
            alu_c = sum[DW];
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_BOOT;
         ir    <= '0;
         strt  <= 1'b0;
      end else begin
         strt <= 1'b0;
         case (state)
            S_BOOT: begin
               if (go) begin
                  ir    <= instr_data;
                  state <= S_RUN;
                  strt  <= 1'b1;
               end
            end
            S_RUN: begin
               if (fetch) begin
                  ir <= instr_data;
                  if (instr_data[15:12] == 4'hF) state <= S_HALT;
                  else strt <= 1'b1;
               end
            end
            S_HALT: state <= S_HALT;
            default: state <= S_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pc <= '0;
      else if (run && incr) pc <= pc + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a  <= '0;
         b  <= '0;
         r  <= '0;
         cy <= 1'b0;
      end else if (active) begin
         if (aluIn1) a <= rd;
         if (aluIn2) b <= rd;
         if (aluOutRegIn) begin
            r  <= alu_y;
            cy <= alu_c;
         end
      end
   end

   // Writeback is placed after the debug port so it wins on an address clash.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) rf[i] <= '0;
      end else begin
         if (dbg_we) rf[dbg_addr] <= dbg_wdata;
         if (active && aluOutRegOut) rf[regIn] <= r;
      end
   end

endmodule

// File: tb/tb_add_datapath.sv
// Directed bench for add_datapath: boot, ALU ops, strobe overlap, PC wrap,
// halt and asynchronous reset.
module tb_add_datapath;
   logic        clk;
   logic        reset;
   logic        go;
   logic [7:0]  instr_addr;
   logic [15:0] instr_data;
   logic [3:0]  opCode;
   logic [5:0]  para1, para2;
   logic        start;
   logic [5:0]  paraOut;
   logic        aluIn1, aluIn2;
   logic [3:0]  control;
   logic        aluOutRegIn, aluOutRegOut;
   logic [5:0]  regIn;
   logic        incr, fetch;
   logic        dbg_we;
   logic [5:0]  dbg_addr;
   logic [7:0]  dbg_wdata;
   logic [7:0]  result;
   logic        carry;
   logic        halted;

   logic [15:0] imem;
   int checks = 0;
   int errors = 0;

   assign instr_data = (instr_addr == 8'hFF) ? 16'h2ABC : imem;

   add_datapath #(.DW(8), .AW(8)) dut (
      .clk(clk), .reset(reset), .go(go),
      .instr_addr(instr_addr), .instr_data(instr_data),
      .opCode(opCode), .para1(para1), .para2(para2), .start(start),
      .paraOut(paraOut), .aluIn1(aluIn1), .aluIn2(aluIn2),
      .control(control), .aluOutRegIn(aluOutRegIn),
      .aluOutRegOut(aluOutRegOut), .regIn(regIn),
      .incr(incr), .fetch(fetch),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .result(result), .carry(carry), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic dbg_write(input logic [5:0] ad, input logic [7:0] d);
      dbg_we = 1; dbg_addr = ad; dbg_wdata = d;
      tick();
      dbg_we = 0;
   endtask

   task automatic ld_a(input logic [5:0] ad);
      paraOut = ad; aluIn1 = 1;
      tick();
      aluIn1 = 0;
   endtask

   task automatic ld_b(input logic [5:0] ad);
      paraOut = ad; aluIn2 = 1;
      tick();
      aluIn2 = 0;
   endtask

   task automatic alu(input logic [3:0] c);
      control = c; aluOutRegIn = 1;
      tick();
      aluOutRegIn = 0;
   endtask

   task automatic wb(input logic [5:0] ad);
      regIn = ad; aluOutRegOut = 1;
      tick();
      aluOutRegOut = 0;
   endtask

   initial begin
      reset = 0; go = 0; imem = 16'h0000;
      paraOut = 0; aluIn1 = 0; aluIn2 = 0; control = 0;
      aluOutRegIn = 0; aluOutRegOut = 0; regIn = 0;
      incr = 0; fetch = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      #3;
      chk("rst_result", result, 0);
      chk("rst_carry", carry, 0);
      chk("rst_pc", instr_addr, 0);
      chk("rst_start", start, 0);
      chk("rst_halted", halted, 0);
      #4 reset = 1;
      tick();

      // boot and ADD
      dbg_write(3, 8'h21);
      dbg_write(4, 8'h12);
      imem = 16'h00C4; go = 1;
      tick();
      go = 0;
      chk("boot_start", start, 1);
      chk("boot_op", opCode, 0);
      chk("boot_p1", para1, 3);
      chk("boot_p2", para2, 4);
      tick();
      chk("boot_start_end", start, 0);
      ld_a(3);
      ld_b(4);
      alu(0);
      chk("add_result", result, 8'h33);
      chk("add_carry", carry, 0);
      wb(5);
      ld_a(5);
      alu(6);
      chk("rf5", result, 8'h33);

      // overflow, borrow, logic clears carry
      dbg_write(10, 8'hF0);
      dbg_write(11, 8'h20);
      dbg_write(12, 8'h01);
      dbg_write(13, 8'h02);
      ld_a(10); ld_b(11); alu(0);
      chk("ovf_result", result, 8'h10);
      chk("ovf_carry", carry, 1);
      ld_a(12); ld_b(13); alu(1);
      chk("sub_result", result, 8'hFF);
      chk("sub_borrow", carry, 1);
      alu(2);
      chk("and_result", result, 8'h00);
      chk("and_carry", carry, 0);
      alu(1);

      // writeback of old R, capture, fetch all together
      imem = 16'h1042;
      control = 7; aluOutRegIn = 1;
      regIn = 20; aluOutRegOut = 1; fetch = 1;
      tick();
      aluOutRegIn = 0; aluOutRegOut = 0; fetch = 0;
      chk("sim_result", result, 8'h02);
      chk("sim_start", start, 1);
      chk("sim_op", opCode, 1);
      chk("sim_p2", para2, 2);
      tick();
      chk("sim_start_end", start, 0);
      ld_a(20); alu(6);
      chk("sim_rf20", result, 8'hFF);

      // PC wrap and fetch from the old PC
      incr = 1;
      for (int i = 0; i < 255; i++) tick();
      incr = 0;
      chk("pc_ff", instr_addr, 8'hFF);
      incr = 1; fetch = 1;
      tick();
      incr = 0; fetch = 0;
      chk("wrap_pc", instr_addr, 0);
      chk("wrap_op", opCode, 2);
      chk("wrap_p1", para1, 6'h2A);
      chk("wrap_p2", para2, 6'h3C);
      chk("wrap_start", start, 1);

      // halt
      imem = 16'hF000; fetch = 1;
      tick();
      fetch = 0;
      chk("halt_flag", halted, 1);
      chk("halt_start", start, 0);
      chk("halt_op", opCode, 4'hF);
      tick();
      chk("halt_start2", start, 0);
      imem = 16'h3041; fetch = 1; incr = 1;
      paraOut = 3; aluIn1 = 1; control = 5; aluOutRegIn = 1;
      tick();
      fetch = 0; incr = 0; aluIn1 = 0; aluOutRegIn = 0;
      chk("halt_hold_op", opCode, 4'hF);
      chk("halt_hold_pc", instr_addr, 0);
      chk("halt_hold_r", result, 8'hFF);
      chk("halt_hold_flag", halted, 1);
      #2 reset = 0;
      #1;
      chk("halt_rst", halted, 0);
      #1 reset = 1;
      tick();

      // reset mid-operation in RUN
      imem = 16'h0000; go = 1;
      tick();
      go = 0;
      incr = 1;
      for (int i = 0; i < 7; i++) tick();
      incr = 0;
      dbg_write(1, 8'h05);
      ld_a(1); alu(6);
      chk("mid_pc", instr_addr, 7);
      chk("mid_result", result, 5);
      #2 reset = 0;
      #1;
      chk("mid_rst_result", result, 0);
      chk("mid_rst_pc", instr_addr, 0);
      chk("mid_rst_op", opCode, 0);
      chk("mid_rst_start", start, 0);
      #1 reset = 1;
      tick();
      imem = 16'h1234; fetch = 1; incr = 1;
      tick();
      fetch = 0; incr = 0;
      chk("boot_ign_pc", instr_addr, 0);
      chk("boot_ign_op", opCode, 0);
      chk("boot_ign_start", start, 0);
      alu(6);
      chk("rst_a_clr", result, 0);
      ld_a(3); alu(6);
      chk("rst_rf_clr", result, 0);
      go = 1;
      tick();
      go = 0;
      chk("reboot_start", start, 1);
      chk("reboot_op", opCode, 1);
      chk("reboot_p1", para1, 6'h08);
      chk("reboot_p2", para2, 6'h34);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
